uart_rx_fifo: RTL
=================

# uart_rx_fifo

Oversampling UART receiver with a runtime baud divisor, per-word error flags and an integrated receive FIFO. It is the next-generation receive path of the UART subsystem: it sits between the synchronised serial input pin and a ready/valid consumer, and absorbs bursts without losing characters. Line errors travel with each word instead of being dropped silently.

## Interface
- DATA_WIDTH, 8: data bits per frame (5..9).
- FIFO_DEPTH, 16: receive FIFO entries; power of two, ≥2.
- DIV_WIDTH, 16: width of the `div` port.
- clk  in  1  system clock.
- rstn  in  1  reset; asynchronous assert, active-low.
- rxd  in  1  serial input, asynchronous to `clk`.
- div  in  DIV_WIDTH  clock cycles per 1/16 bit; 0 is treated as 1; sampled at every frame start.
- parity_odd  in  1  parity select: 1 = odd, 0 = even. Present only with `UART_RX_PARITY_EN`.
- rd_data  out  DATA_WIDTH  head-of-FIFO data.
- rd_frame_err  out  1  head word had a low stop bit.
- rd_parity_err  out  1  head word failed parity; tied 0 without the macro.
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  consumer accepts the head word.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- clr_overflow  in  1  single-cycle pulse clears `overflow`.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  occupancy.
- busy  out  1  receive FSM is not in IDLE.

## Operation
- `rxd` passes through a 2-flop synchroniser with reset value 1.
- Tick generator: counter runs 0..max(div,1)-1 and pulses `tick` at the terminal count. The counter restarts at 0 on entry to START.
- Oversample counter `os`, 0..15: advances on each tick. Each bit is resolved by majority of samples at os = 7, 8, 9. Decision at os = 9; the bit ends at os = 15.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
  - IDLE: synced `rxd` = 0 → START.
  - START: majority 1 → IDLE (false start, nothing pushed). Otherwise → DATA at os = 15.
  - DATA: DATA_WIDTH bits, LSB first. After the last bit → PARITY, or → STOP without the macro.
  - PARITY: compare the received bit with the computed parity (even/odd per `parity_odd`); the mismatch is latched.
  - STOP: push {parity_err, frame_err, data} at the decision tick (os = 9). Go to IDLE if the stop bit was 1, else to BREAK.
  - BREAK: wait for synced `rxd` = 1, then IDLE.
- FIFO push when full: the word is discarded and `overflow` is set. `overflow` holds until `clr_overflow`; if a set and a clear occur in the same cycle, set wins.
- Pop occurs on `rd_valid && rd_ready`. A simultaneous push and pop is always accepted, even when full; the count is unchanged.
- `div` changes mid-frame take effect at the next START.

## Timing
- Reset values: `rd_data` = 0, `rd_frame_err` = 0, `rd_parity_err` = 0, `rd_valid` = 0, `overflow` = 0, `fifo_count` = 0, `busy` = 0. FSM resets to IDLE and the FIFO is emptied.
- Start detect: 2 synchroniser cycles plus 1 cycle to enter START.
- Push occurs the cycle after the stop-bit decision tick. `rd_valid`, `rd_data` and `fifo_count` update on the following edge (registered, first-word-fall-through).
- `rd_data` and the error flags stay stable while `rd_valid && !rd_ready`.
- Reset asserted mid-frame aborts the frame immediately; no partial word is ever pushed.
- Sustained throughput: back-to-back frames with a single stop bit, with no idle gap required.

## Configuration
- `UART_RX_PARITY_EN` defined: PARITY state, `parity_odd` port and `rd_parity_err` generation are all built in.
- `UART_RX_PARITY_EN` undefined: there is no parity bit in the frame, the `parity_odd` port is absent, and `rd_parity_err` is constant 0.

## Structure
- Package `uart_pkg`: FSM state enum `rx_state_t`, the oversample constant `OS_RATE = 16`, the sample indices 7/8/9, and the FIFO entry struct {parity_err, frame_err, data}.
- Sub-module `uart_sync_fifo`: parameterised synchronous first-word-fall-through FIFO (width, depth) with count output. It is reused by the planned TX FIFO.

## Test plan
- 0xA5 at div = 54, 8N1 → `rd_valid` rises with `rd_data` = 0xA5 and both errors 0. Asserting `rd_ready` for one cycle → `rd_valid` = 0 and `fifo_count` = 0.
- Low glitch of 3 ticks on an idle line → `busy` pulses, then returns to IDLE. Nothing is pushed and `fifo_count` stays 0.
- Frame 0x3C with stop bit 0, then line high → word 0x3C with `rd_frame_err` = 1. The FSM passes through BREAK and the next frame 0x55 is received clean.
- 17 frames with `rd_ready` = 0 and FIFO_DEPTH = 16 → `fifo_count` = 16 and `overflow` = 1. The first 16 words read back in order; the 17th is absent. A `clr_overflow` pulse → `overflow` = 0.
- Macro defined, `parity_odd` = 0, frame 0x07 sent with parity bit 0 → `rd_parity_err` = 1. Resent with parity bit 1 → `rd_parity_err` = 0.
- `rstn` pulsed low mid-DATA → all outputs at reset values. The next frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Optional parity support is selected in the top with UART_RX_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } rx_state_t;

    localparam int          OS_RATE        = 16;
    localparam logic [3:0]  SMP_LO         = 4'd7;
    localparam logic [3:0]  SMP_MID        = 4'd8;
    localparam logic [3:0]  SMP_HI         = 4'd9;
    localparam logic [3:0]  OS_LAST        = 4'(OS_RATE - 1);
    localparam int          MAX_DATA_WIDTH = 9;

    // One received word with its line-error flags; data is right-aligned.
    typedef struct packed {
        logic                      parity_err;
        logic                      frame_err;
        logic [MAX_DATA_WIDTH-1:0] data;
    } rx_entry_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// A write while full is accepted only if a read happens in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             valid_o,
    output logic             full_o,
    output logic [CW-1:0]    count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_rd, do_wr;

    assign valid_o   = (count_q != '0);
    assign full_o    = (count_q == CW'(DEPTH));
    assign count_o   = count_q;
    assign do_rd     = rd_en_i && valid_o;
    assign do_wr     = wr_en_i && (!full_o || do_rd);
    // Empty FIFO presents zero so the head is never undefined.
    assign rd_data_o = valid_o ? mem_q[rptr_q] : '0;

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wptr_q] <= wr_data_i;
    end

    // Pointers and count; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + AW'(1);
            if (do_rd) rptr_q <= rptr_q + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 16x oversampling UART receiver feeding a FWFT receive FIFO.
// Define UART_RX_PARITY_EN to add a parity bit, parity_odd input and parity checking.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               rxd,
    input  logic [DIV_WIDTH-1:0]               div,
`ifdef UART_RX_PARITY_EN
    input  logic                               parity_odd,
`endif
    output logic [DATA_WIDTH-1:0]              rd_data,
    output logic                               rd_frame_err,
    output logic                               rd_parity_err,
    output logic                               rd_valid,
    input  logic                               rd_ready,
    output logic                               overflow,
    input  logic                               clr_overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic                               busy
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    logic [1:0]            sync_q;
    logic                  rxd_s;
    rx_state_t             state_q;
    logic [DIV_WIDTH-1:0]  div_q, tcnt_q, div_eff;
    logic [3:0]            os_q;
    logic [1:0]            samp_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [BW-1:0]         bit_q;
    logic                  par_err_q, push_q, overflow_q;
    rx_entry_t             push_entry_q, head;
    logic                  tick, dec, bit_end, bit_val, pop, full;
    logic                  unused_head;

    assign rxd_s   = sync_q[1];
    assign div_eff = (div == '0) ? DIV_WIDTH'(1) : div;
    assign tick    = (tcnt_q == div_q - DIV_WIDTH'(1));
    assign dec     = tick && (os_q == SMP_HI);
    assign bit_end = tick && (os_q == OS_LAST);
    assign bit_val = maj3(samp_q[0], samp_q[1], rxd_s);
    assign pop     = rd_valid && rd_ready;
    assign busy    = (state_q != S_IDLE);

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], rxd};
    end

    // Tick generator, oversample counter, majority samples and the receive FSM.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            div_q        <= DIV_WIDTH'(1);
            tcnt_q       <= '0;
            os_q         <= '0;
            samp_q       <= '0;
            data_q       <= '0;
            bit_q        <= '0;
            par_err_q    <= 1'b0;
            push_q       <= 1'b0;
            push_entry_q <= '0;
        end else begin
            push_q <= 1'b0;
            tcnt_q <= tick ? '0 : tcnt_q + DIV_WIDTH'(1);
            if (tick)                      os_q      <= os_q + 4'd1;
            if (tick && os_q == SMP_LO)    samp_q[0] <= rxd_s;
            if (tick && os_q == SMP_MID)   samp_q[1] <= rxd_s;
            case (state_q)
                S_IDLE: if (!rxd_s) begin
                    // Latch the divisor and realign the bit clock to the falling edge.
                    state_q   <= S_START;
                    div_q     <= div_eff;
                    tcnt_q    <= '0;
                    os_q      <= '0;
                    bit_q     <= '0;
                    par_err_q <= 1'b0;
                end
                S_START: begin
                    if (dec && bit_val) state_q <= S_IDLE;
                    else if (bit_end)   state_q <= S_DATA;
                end
                S_DATA: begin
                    if (dec) data_q <= {bit_val, data_q[DATA_WIDTH-1:1]};
                    if (bit_end) begin
                        if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_q <= bit_q + BW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (dec)     par_err_q <= bit_val ^ (^data_q) ^ parity_odd;
                    if (bit_end) state_q   <= S_STOP;
                end
`endif
                S_STOP: if (dec) begin
                    // Leave at mid stop bit so a back-to-back start edge is caught.
                    push_q       <= 1'b1;
                    push_entry_q <= '{parity_err: par_err_q,
                                      frame_err:  !bit_val,
                                      data:       MAX_DATA_WIDTH'(data_q)};
                    state_q      <= bit_val ? S_IDLE : S_BREAK;
                end
                S_BREAK: if (rxd_s) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Sticky overflow on a dropped word; a set in the same cycle beats a clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                       overflow_q <= 1'b0;
        else if (push_q && full && !pop) overflow_q <= 1'b1;
        else if (clr_overflow)           overflow_q <= 1'b0;
    end

    uart_sync_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .wr_en_i   (push_q),
        .wr_data_i (push_entry_q),
        .rd_en_i   (rd_ready),
        .rd_data_o (head),
        .valid_o   (rd_valid),
        .full_o    (full),
        .count_o   (fifo_count)
    );

    assign rd_data       = head.data[DATA_WIDTH-1:0];
    assign rd_frame_err  = head.frame_err;
`ifdef UART_RX_PARITY_EN
    assign rd_parity_err = head.parity_err;
`else
    assign rd_parity_err = 1'b0;
`endif
    assign overflow      = overflow_q;
    assign unused_head   = ^{head.data, head.parity_err};

endmodule
